// File: rtl/vedic_8x8_pipe.sv
// 8x8 unsigned Vedic multiplier in a three-register elastic pipeline.
// Operands are registered, four 4x4 Vedic cores form the partial products, then they are summed.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic x10, x01, x11, cy;

  assign x10  = a[1] & b[0];
  assign x01  = a[0] & b[1];
  assign x11  = a[1] & b[1];
  assign cy   = x10 & x01;
  assign p[0] = a[0] & b[0];
  assign p[1] = x10 ^ x01;
  assign p[2] = x11 ^ cy;
  assign p[3] = x11 & cy;
endmodule

module vedic_4_x_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic_8x8_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c
);
  localparam int STAGES    = 3;
  localparam int NUM_LANES = 4;

  logic [STAGES:1]               vld_pipe;
  logic                          adv;
  logic [7:0]                    a_r, b_r;
  logic [NUM_LANES-1:0][3:0]     an, bn;
  logic [NUM_LANES-1:0][7:0]     pp_w, pp_r;
  logic [15:0]                   sum;

  // One stall signal freezes every stage; bubbles never block since out_valid=0 forces adv.
  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // Lane i: bit 0 picks the a nibble, bit 1 picks the b nibble (pp0..pp3).
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign an[i] = ((i % 2) == 1) ? a_r[7:4] : a_r[3:0];
      assign bn[i] = (i >= 2)       ? b_r[7:4] : b_r[3:0];
      vedic_4_x_4 u_pp (.a(an[i]), .b(bn[i]), .p(pp_w[i]));
    end
  endgenerate

  assign sum = {8'b0, pp_r[0]} + {4'b0, pp_r[1], 4'b0} + {4'b0, pp_r[2], 4'b0}
             + {pp_r[3], 8'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_r      <= '0;
      b_r      <= '0;
      pp_r     <= '0;
      c        <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end
      if (vld_pipe[1]) pp_r <= pp_w;
      if (vld_pipe[2]) c    <= sum;
    end
  end
endmodule
